// File: rtl/n1_sbus_master.sv
// Stack bus Wishbone master: runs one pipelined Wishbone cycle per PRS request
// using the AGU-supplied address/tags, and reports done, bus error or timeout.
module n1_sbus_master #(
    parameter int unsigned SP_WIDTH   = 12,
    parameter int unsigned CELL_WIDTH = 16,
    parameter int unsigned TO_WIDTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  async_rst_i,

    input  logic [SP_WIDTH-1:0]   sagu2sbus_adr_i,
    input  logic                  sagu2sbus_tga_ps_i,
    input  logic                  sagu2sbus_tga_rs_i,

    input  logic                  prs2sbus_req_i,
    input  logic                  prs2sbus_we_i,
    input  logic [CELL_WIDTH-1:0] prs2sbus_dat_i,
    output logic                  sbus2prs_busy_o,
    output logic                  sbus2prs_done_o,
    output logic [CELL_WIDTH-1:0] sbus2prs_dat_o,

    output logic                  sbus2excpt_buserr_o,
    output logic                  sbus2excpt_timeout_o,

    output logic                  sbus_cyc_o,
    output logic                  sbus_stb_o,
    output logic                  sbus_we_o,
    output logic [SP_WIDTH-1:0]   sbus_adr_o,
    output logic                  sbus_tga_ps_o,
    output logic                  sbus_tga_rs_o,
    output logic [CELL_WIDTH-1:0] sbus_dat_o,
    input  logic                  sbus_ack_i,
    input  logic                  sbus_stall_i,
    input  logic                  sbus_err_i,
    input  logic [CELL_WIDTH-1:0] sbus_dat_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [TO_WIDTH-1:0] TO_LIMIT = '1;
    localparam logic [TO_WIDTH-1:0] TO_LAST  = TO_LIMIT - 1'b1;

    state_t                state_q, state_d;
    logic [TO_WIDTH-1:0]   cnt_q, cnt_d;

    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [SP_WIDTH-1:0]   adr_q, adr_d;
    logic                  tga_ps_q, tga_ps_d;
    logic                  tga_rs_q, tga_rs_d;
    logic [CELL_WIDTH-1:0] wdat_q, wdat_d;
    logic [CELL_WIDTH-1:0] rdat_q, rdat_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  buserr_q, buserr_d;
    logic                  timeout_q, timeout_d;

    logic in_bus;
    logic resp_ok;
    logic fin_ack;
    logic fin_err;
    logic fin_to;
    logic finish;
    logic accept;

    // A response only counts once the address phase is accepted (WAIT, or ADDR without stall).
    assign in_bus  = (state_q != ST_IDLE);
    assign resp_ok = (state_q == ST_WAIT) || ((state_q == ST_ADDR) && !sbus_stall_i);
    assign fin_err = resp_ok && sbus_err_i;
    assign fin_ack = resp_ok && sbus_ack_i && !sbus_err_i;
    assign fin_to  = in_bus && !fin_err && !fin_ack && (cnt_q == TO_LAST);
    assign finish  = fin_ack || fin_err || fin_to;

    // The completion-pulse cycle is a dead cycle for new requests.
    assign accept  = (state_q == ST_IDLE) && prs2sbus_req_i
                     && !(done_q || buserr_q || timeout_q);

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            tga_ps_q  <= 1'b0;
            tga_rs_q  <= 1'b0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            buserr_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            tga_ps_q  <= tga_ps_d;
            tga_rs_q  <= tga_rs_d;
            wdat_q    <= wdat_d;
            rdat_q    <= rdat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            buserr_q  <= buserr_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                end
            end
            ST_ADDR: begin
                if (finish) begin
                    state_d = ST_IDLE;
                end else if (!sbus_stall_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (finish) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (in_bus && (cnt_q != TO_LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        cyc_d     = (state_d != ST_IDLE);
        stb_d     = (state_d == ST_ADDR);
        busy_d    = (state_d != ST_IDLE);
        done_d    = fin_ack;
        buserr_d  = fin_err;
        timeout_d = fin_to;
        we_d      = we_q;
        adr_d     = adr_q;
        tga_ps_d  = tga_ps_q;
        tga_rs_d  = tga_rs_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
        if (accept) begin
            we_d     = prs2sbus_we_i;
            adr_d    = sagu2sbus_adr_i;
            tga_ps_d = sagu2sbus_tga_ps_i;
            tga_rs_d = sagu2sbus_tga_rs_i;
            wdat_d   = prs2sbus_dat_i;
        end
        if (fin_ack && !we_q) begin
            rdat_d = sbus_dat_i;
        end
    end

    assign sbus_cyc_o           = cyc_q;
    assign sbus_stb_o           = stb_q;
    assign sbus_we_o            = we_q;
    assign sbus_adr_o           = adr_q;
    assign sbus_tga_ps_o        = tga_ps_q;
    assign sbus_tga_rs_o        = tga_rs_q;
    assign sbus_dat_o           = wdat_q;
    assign sbus2prs_dat_o       = rdat_q;
    assign sbus2prs_busy_o      = busy_q;
    assign sbus2prs_done_o      = done_q;
    assign sbus2excpt_buserr_o  = buserr_q;
    assign sbus2excpt_timeout_o = timeout_q;

endmodule

// File: doc/n1_sbus_master.md
Name: n1_sbus_master

Overview:
- Stack bus Wishbone master.
- Sits directly downstream of the stack bus AGU: takes the AGU's stack address and PS/RS tag, plus write data and command from the PRS, and runs one pipelined Wishbone cycle on the stack bus.
- Returns read data and completion to the PRS; reports bus errors and timeouts to the exception unit.
- Only one transaction is outstanding at a time.

Parameters:
- SP_WIDTH, 12: stack address width; matches the AGU address output.
- CELL_WIDTH, 16: data cell width.
- TO_WIDTH, 4: timeout counter width; the timeout limit is 2^TO_WIDTH-1 cycles.

Ports:
- clk_i  in  1  system clock
- async_rst_i  in  1  asynchronous reset, active-low
- sagu2sbus_adr_i  in  SP_WIDTH  stack address from AGU
- sagu2sbus_tga_ps_i  in  1  PS access tag from AGU
- sagu2sbus_tga_rs_i  in  1  RS access tag from AGU
- prs2sbus_req_i  in  1  transaction request
- prs2sbus_we_i  in  1  1:write (push), 0:read (pull)
- prs2sbus_dat_i  in  CELL_WIDTH  write data
- sbus2prs_busy_o  out  1  transaction in progress
- sbus2prs_done_o  out  1  one-cycle completion pulse
- sbus2prs_dat_o  out  CELL_WIDTH  captured read data
- sbus2excpt_buserr_o  out  1  one-cycle bus error pulse
- sbus2excpt_timeout_o  out  1  one-cycle timeout pulse
- sbus_cyc_o  out  1  Wishbone cycle
- sbus_stb_o  out  1  Wishbone strobe
- sbus_we_o  out  1  Wishbone write enable
- sbus_adr_o  out  SP_WIDTH  Wishbone address
- sbus_tga_ps_o  out  1  PS tag
- sbus_tga_rs_o  out  1  RS tag
- sbus_dat_o  out  CELL_WIDTH  Wishbone write data
- sbus_ack_i  in  1  Wishbone acknowledge
- sbus_stall_i  in  1  Wishbone pipeline stall
- sbus_err_i  in  1  Wishbone error
- sbus_dat_i  in  CELL_WIDTH  Wishbone read data

Behaviour:
- All outputs are registered.
- Reset state: every output 0, FSM in IDLE, timeout counter 0.
- IDLE: busy=0. If req_i=1 in cycle N, latch adr, tga_ps, tga_rs, we and dat, clear the counter and go to ADDR. In cycle N+1: cyc=stb=1, busy=1, and the bus outputs carry the latched values. The latched values are held stable until the transaction ends.
- ADDR (stb=1):
  - stall=1: stay in ADDR and keep stb asserted.
  - stall=0: the address phase is accepted; stb drops the next cycle and the FSM goes to WAIT.
  - stall=0 and ack=1 in the same cycle: complete immediately, as in WAIT.
- WAIT (cyc=1, stb=0):
  - ack=1: capture sbus_dat_i into sbus2prs_dat_o (reads only; writes leave it unchanged), pulse done for one cycle, drop cyc and go to IDLE.
  - err=1 (priority over ack): pulse buserr, drop cyc, go to IDLE, no done pulse, read data unchanged.
- Timeout:
  - The counter increments every cycle spent in ADDR or WAIT and saturates.
  - When it reaches 2^TO_WIDTH-1 without ack or err, pulse timeout, drop cyc and stb, and go to IDLE with no done pulse.
  - A late ack or err arriving in IDLE is ignored.
- Back-to-back: busy clears in the cycle done/buserr/timeout asserts. req_i is sampled only in IDLE, so the earliest next request is accepted one cycle after the pulse and its stb rises two cycles after the pulse. Minimum request-to-request spacing is 3 cycles with a zero-wait slave.
- req_i while busy=1 is ignored; the PRS holds req_i until it sees busy.
- Exactly one of done, buserr or timeout pulses per accepted request.
- tga_ps/tga_rs are passed through unmodified; both 0 or both 1 is not checked.
- An async reset mid-transaction returns the block to IDLE immediately and clears cyc and stb, with no completion pulse.
- Address arithmetic is done by the AGU; this block does no wrap or overflow checking.

Test Plan:
- Write, zero-wait slave: req=1, we=1, adr=0x7FF, tga_ps=1, dat=0xBEEF; slave stall=0, ack in the first WAIT cycle -> cyc/stb high in N+1 with adr 0x7FF and dat_o 0xBEEF, done pulses in N+3, busy low from N+3.
- Read with stall: req=1, we=0, adr=0x003, tga_rs=1; stall=1 for 3 cycles, ack one cycle after acceptance with dat_i=0x1234 -> stb high for 4 cycles, done pulse, sbus2prs_dat_o=0x1234.
- Bus error: read request, slave asserts err and ack together -> buserr pulses once, no done, dat_o retains its previous value, cyc low the next cycle.
- Timeout: TO_WIDTH=4, slave never acks -> timeout pulses after 15 cycles in ADDR/WAIT, cyc/stb low the next cycle; a later spurious ack causes no done.
- Reset mid-cycle: assert async_rst_i=0 in WAIT -> cyc, stb, busy and data outputs are 0 immediately; after release the next request runs normally.
- Back-to-back requests: req held continuously -> second stb rises exactly 2 cycles after the first done pulse; req asserted while busy is ignored.
